// File: rtl/smu_traceback.sv
// smu_traceback -- block-based Viterbi survivor-memory traceback.
//
// Collects DEPTH survivor decision vectors, picks the minimum path-metric
// state of the last symbol as the traceback start, walks the survivor
// memory backwards for DEPTH cycles, then emits the decoded bits in
// time order, one per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   decision vector / metrics valid
//   in_ready   block accepts a symbol (FILL only)
//   dec        survivor decision bits, dec[s] = select bit of state s
//   pm         unsigned path metrics, state s at [s*MW +: MW]
//   out_valid  one-cycle pulse per decoded bit
//   out_bit    decoded bit, held while out_valid is low
//   best_state traceback start state of the current block
module smu_traceback #(
    parameter int K     = 4,
    parameter int MW    = 3,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [(1<<(K-1))-1:0]      dec,
    input  logic [(1<<(K-1))*MW-1:0]   pm,
    output logic                       out_valid,
    output logic                       out_bit,
    output logic [K-2:0]               best_state
);

    localparam int unsigned S    = 1 << (K - 1);
    localparam int unsigned SW   = K - 1;
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACE = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_ptr;
    logic [SW-1:0]   r_cur;
    logic [SW-1:0]   r_best;
    logic [S-1:0]    r_mem  [DEPTH];
    logic            r_bits [DEPTH];

    logic            w_accept;
    logic [SW-1:0]   w_argmin;
    logic [MW-1:0]   w_minval;
    logic            w_sel;
    logic [SW-1:0]   w_cur_next;

    assign in_ready   = (r_state == FILL);
    assign w_accept   = in_valid && in_ready;
    assign best_state = r_best;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_argmin = '0;
        w_minval = pm[MW-1:0];
        for (int unsigned s = 1; s < S; s++) begin
            if (pm[s*MW +: MW] < w_minval) begin
                w_minval = pm[s*MW +: MW];
                w_argmin = SW'(s);
            end
        end
    end

    // Predecessor state: shift in the survivor select bit of the current state.
    always_comb begin
        w_sel      = r_mem[r_ptr][r_cur];
        w_cur_next = {r_cur[SW-2:0], w_sel};
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= FILL;
            r_wr_ptr  <= '0;
            r_ptr     <= '0;
            r_cur     <= '0;
            r_best    <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (r_wr_ptr == LAST) begin
                            // wr_ptr parks on the last slot (never DEPTH) and is
                            // cleared when the block finishes emitting.
                            r_best  <= w_argmin;
                            r_cur   <= w_argmin;
                            r_ptr   <= LAST;
                            r_state <= TRACE;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PW'(1);
                        end
                    end
                end
                TRACE: begin
                    r_cur <= w_cur_next;
                    if (r_ptr == '0) begin
                        r_state <= EMIT;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr - PW'(1);
                    end
                end
                EMIT: begin
                    out_valid <= 1'b1;
                    out_bit   <= r_bits[r_ptr];
                    if (r_ptr == LAST) begin
                        r_state  <= FILL;
                        r_wr_ptr <= '0;
                    end else begin
                        r_ptr <= r_ptr + PW'(1);
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // Survivor memory and decoded-bit buffer are storage only; not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= dec;
        end
        if (r_state == TRACE) begin
            r_bits[r_ptr] <= r_cur[SW-1];
        end
    end

endmodule

// File: tb/tb_smu_traceback.sv
// tb_smu_traceback -- self-checking bench for smu_traceback.
//
// Two instances (K=4, MW=3): DEPTH=4 driven from a table of hand-derived
// vectors, DEPTH=5 driven with random blocks against a reference model.
// Expected bits, with the cycle each must appear in, are queued when a
// block's last symbol is accepted and popped when out_valid is seen.
module tb_smu_traceback;

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_bit;
    logic [7:0]  a_dec;
    logic [23:0] a_pm;
    logic [2:0]  a_best;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_bit;
    logic [7:0]  b_dec;
    logic [23:0] b_pm;
    logic [2:0]  b_best;

    smu_traceback #(.K(4), .MW(3), .DEPTH(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .dec        (a_dec),
        .pm         (a_pm),
        .out_valid  (a_out_valid),
        .out_bit    (a_out_bit),
        .best_state (a_best)
    );

    smu_traceback #(.K(4), .MW(3), .DEPTH(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .dec        (b_dec),
        .pm         (b_pm),
        .out_valid  (b_out_valid),
        .out_bit    (b_out_bit),
        .best_state (b_best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int a_pulses = 0;

    typedef struct {
        logic b;
        int   t;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    typedef struct {
        logic [31:0] decs;   // {dec3, dec2, dec1, dec0}
        logic [23:0] pm;     // metrics of the last symbol
        logic [2:0]  best;
        logic [3:0]  bits;   // bits[0] is emitted first
    } vec_t;
    vec_t tbl [5];

    logic [7:0]  blk_dec [8];
    logic [23:0] blk_pm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? a_in_ready : b_in_ready;
    endfunction

    function automatic logic [2:0] bst(input int which);
        return (which == 0) ? a_best : b_best;
    endfunction

    // Scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (a_out_valid === 1'b1) a_pulses++;
        if (rst === 1'b1 && a_out_valid === 1'b1) begin
            if (qa.size() == 0) begin
                n_checks++;
                $display("FAIL a_unexpected_out: got out_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = qa.pop_front();
                chk("a_out_bit", 32'(a_out_bit), 32'(e.b));
                chk("a_out_cycle", cyc, e.t);
            end
        end
        if (rst === 1'b1 && b_out_valid === 1'b1) begin
            if (qb.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected_out: got out_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = qb.pop_front();
                chk("b_out_bit", 32'(b_out_bit), 32'(e.b));
                chk("b_out_cycle", cyc, e.t);
            end
        end
    end

    // Independent reference: argmin (lowest index on tie) then backward walk.
    function automatic void ref_model(input int depth, output logic [2:0] best,
                                      output logic [15:0] bits);
        int bi;
        logic [2:0] st;
        bi = 0;
        for (int s = 1; s < 8; s++)
            if (blk_pm[s*3 +: 3] < blk_pm[bi*3 +: 3]) bi = s;
        best = 3'(bi);
        st   = best;
        bits = '0;
        for (int p = depth - 1; p >= 0; p--) begin
            bits[p] = st[2];
            st      = {st[1:0], blk_dec[p][st]};
        end
    endfunction

    // Called at a negedge; returns at the negedge after the last accept.
    // in_valid is left high so a following call keeps it asserted.
    task automatic send_block(input int which, input int depth, input logic [2:0] exp_best,
                              input logic [15:0] exp_bits, input bit do_push, output int waits);
        int   guard;
        int   t_last;
        exp_t e;
        waits = 0;
        for (int i = 0; i < depth; i++) begin
            if (which == 0) begin
                a_in_valid = 1'b1;
                a_dec      = blk_dec[i];
                a_pm       = (i == depth - 1) ? blk_pm : 24'($urandom);
            end else begin
                b_in_valid = 1'b1;
                b_dec      = blk_dec[i];
                b_pm       = (i == depth - 1) ? blk_pm : 24'($urandom);
            end
            guard = 0;
            while (rdy(which) !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            waits += guard;
            if (guard >= 200) begin
                n_checks++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", guard);
            end
            @(posedge clk);
            @(negedge clk);
        end
        t_last = cyc;
        chk("best_state", 32'(bst(which)), 32'(exp_best));
        if (do_push) begin
            for (int j = 0; j < depth; j++) begin
                e.b = exp_bits[j];
                e.t = t_last + depth + 1 + j;
                if (which == 0) qa.push_back(e);
                else qb.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((qa.size() != 0 || qb.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d bits pending, expected 0", qa.size() + qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < 4; i++) blk_dec[i] = tbl[v].decs[i*8 +: 8];
        blk_pm = tbl[v].pm;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [2:0]  eb;
        logic [15:0] ebits;

        tbl[0] = '{decs: 32'h00000000, pm: 24'hFFFFF8, best: 3'd0, bits: 4'b0000};
        tbl[1] = '{decs: 32'hFFFFFFFF, pm: 24'h16DB6D, best: 3'd7, bits: 4'b1111};
        tbl[2] = '{decs: 32'h01813C0F, pm: 24'h6DB6DB, best: 3'd0, bits: 4'b0001};
        tbl[3] = '{decs: 32'h041000FF, pm: 24'h65B65B, best: 3'd2, bits: 4'b0101};
        tbl[4] = '{decs: 32'h2099C35A, pm: 24'h914927, best: 3'd5, bits: 4'b1011};

        rst        = 1'b1;
        a_in_valid = 1'b0; a_dec = '0; a_pm = '0;
        b_in_valid = 1'b0; b_dec = '0; b_pm = '0;

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #22 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_bit", 32'(a_out_bit), 32'd0);
        chk("rst_best_state", 32'(a_best), 32'd0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 32'(a_in_ready), 32'd1);
        @(negedge clk);

        // Table vectors, one isolated block each.
        for (int v = 0; v < 5; v++) begin
            load_vec(v);
            send_block(0, 4, tbl[v].best, {12'b0, tbl[v].bits}, 1'b1, w);
            a_in_valid = 1'b0;
            drain();
            repeat (2) @(negedge clk);
            chk("hold_out_valid", 32'(a_out_valid), 32'd0);
            chk("hold_out_bit", 32'(a_out_bit), 32'(tbl[v].bits[3]));
        end

        // in_valid held high across three back-to-back blocks.
        load_vec(1);
        send_block(0, 4, tbl[1].best, {12'b0, tbl[1].bits}, 1'b1, w);
        chk("bp_waits_blk1", w, 0);
        load_vec(3);
        send_block(0, 4, tbl[3].best, {12'b0, tbl[3].bits}, 1'b1, w);
        chk("bp_waits_blk2", w, 8);
        load_vec(4);
        send_block(0, 4, tbl[4].best, {12'b0, tbl[4].bits}, 1'b1, w);
        chk("bp_waits_blk3", w, 8);
        a_in_valid = 1'b0;
        drain();
        @(negedge clk);

        // Reset during the second TRACE cycle abandons the block.
        load_vec(2);
        send_block(0, 4, tbl[2].best, {12'b0, tbl[2].bits}, 1'b0, w);
        a_in_valid = 1'b0;
        a_pulses   = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(a_in_ready), 32'd1);
        chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (16) @(negedge clk);
        chk("midrst_no_output", a_pulses, 0);

        // DEPTH=5 instance: random blocks against the reference model.
        for (int blk = 0; blk < 3; blk++) begin
            for (int i = 0; i < 5; i++) blk_dec[i] = 8'($urandom);
            blk_pm = 24'($urandom);
            if (blk == 0) blk_pm = 24'h6DB6DB;
            ref_model(5, eb, ebits);
            send_block(1, 5, eb, ebits, 1'b1, w);
            b_in_valid = 1'b0;
            drain();
            repeat (2) @(negedge clk);
            chk("b_hold_out_bit", 32'(b_out_bit), 32'(ebits[4]));
        end

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/smu_traceback.md
SMU_TRACEBACK -- requirements
Module: smu_traceback

Interface
REQ-001 The block SHALL have parameter K, default 4, meaning constraint length; the number of trellis states is S = 2^(K-1), with K from 3 to 7.
REQ-002 The block SHALL have parameter MW, default 3, meaning the unsigned path-metric width per state.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning the traceback block length in symbols, with DEPTH >= 2.
REQ-004 clk  input  1  The single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  Asynchronous, active-low reset.
REQ-006 in_valid  input  1  Decision vector and metrics valid this cycle.
REQ-007 in_ready  output  1  Block accepts a symbol this cycle.
REQ-008 dec  input  S  Survivor decision bits; dec[s] is the select bit of state s.
REQ-009 pm  input  S*MW  Unsigned path metrics; state s occupies bits [s*MW +: MW].
REQ-010 out_valid  output  1  Decoded bit valid, asserted as a one-cycle pulse per bit.
REQ-011 out_bit  output  1  Decoded bit, delivered in time order.
REQ-012 best_state  output  K-1  Traceback start state of the current block.

Function
REQ-013 The block SHALL implement an FSM with states FILL, TRACE and EMIT; in_ready SHALL be 1 only in FILL.
REQ-014 A symbol SHALL be accepted only when in_valid=1 and in_ready=1; on acceptance, dec SHALL be written to mem[wr_ptr] and wr_ptr SHALL increment.
REQ-015 FILL, accept with wr_ptr=DEPTH-1: best_state SHALL be registered as the argmin of pm in that same cycle, ptr SHALL be set to DEPTH-1, cur SHALL be set to argmin, and the FSM SHALL go to TRACE.
REQ-016 The argmin SHALL use unsigned compare; on a tie, the lowest state index SHALL win.
REQ-017 TRACE, each cycle: bits[ptr] SHALL be set to cur[K-2]; cur SHALL become ((cur<<1) mod S) | mem[ptr][cur]; ptr SHALL decrement.
REQ-018 TRACE with ptr=0: after that step the FSM SHALL go to EMIT and ptr SHALL be set to 0, so TRACE lasts exactly DEPTH cycles.
REQ-019 EMIT, each cycle: out_valid SHALL be 1, out_bit SHALL be bits[ptr], and ptr SHALL increment.
REQ-020 EMIT with ptr=DEPTH-1: after that cycle the FSM SHALL go to FILL and wr_ptr SHALL be set to 0, so EMIT lasts exactly DEPTH cycles.
REQ-021 out_valid and out_bit SHALL be registered; out_bit SHALL hold its last value when out_valid=0.
REQ-022 Latency: if the last symbol of a block is accepted at edge t, the first out_valid=1 SHALL be at cycle t+DEPTH+1, and the last at t+2*DEPTH.
REQ-023 in_valid asserted during TRACE or EMIT SHALL cause no write and no state change; upstream SHALL hold its data.
REQ-024 There is no output backpressure; every decoded bit SHALL be emitted exactly once.
REQ-025 The pointer wrap SHALL be exact for any DEPTH, including non-powers of two: no out-of-range memory index SHALL occur.
REQ-026 The survivor memory SHALL be a DEPTH x S register array, written only in FILL.

Reset
REQ-027 On rst=0, the FSM SHALL go to FILL, wr_ptr, ptr and cur SHALL be 0, best_state SHALL be 0, out_valid SHALL be 0 and out_bit SHALL be 0, all immediately and without waiting for clk.
REQ-028 The survivor memory and bits array SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-TRACE or mid-EMIT SHALL abandon the block, and no further out_valid SHALL be asserted for it.
REQ-030 On the first rising edge after rst returns to 1, in_ready SHALL be 1.

Verification (K=4, MW=3, DEPTH=4 unless stated)
REQ-031 Reset: drive rst=0 asynchronously mid-cycle -> in_ready=1, out_valid=0, out_bit=0 and best_state=0 with no clock edge.
REQ-032 Zero path: 4 symbols with dec=8'h00, pm[0]=0 and all other pm=7 -> best_state=0, outputs 0,0,0,0, first out_valid exactly 5 cycles after the last accept.
REQ-033 All-ones path: 4 symbols with dec=8'hFF, pm[7]=0 and all other pm=5 -> best_state=7, outputs 1,1,1,1.
REQ-034 Tie break: last symbol with all pm=3 -> best_state=0; all pm=3 except pm[2]=pm[6]=1 -> best_state=2.
REQ-035 Backpressure: in_valid held at 1 continuously -> in_ready low for exactly 8 cycles per block, 4 accepts per block, no lost or duplicated bits over 3 blocks.
REQ-036 Mid-block reset: pulse rst=0 at the 2nd TRACE cycle -> no out_valid for that block; a new block with DEPTH=5 decodes correctly against a reference model.
